multicycle_controller: RTL

//  Moore-FSM main controller for the multicycle MIPS datapath. Sequences instruction fetch,

---
 rtl/multicycle_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: a Moore machine that steps each
// instruction through fetch, decode, execute, memory and writeback.
module multicycle_controller #(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [2:0] ALUcontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     r_state;
    state_t     w_nextState;
    state_t     w_evalState;

    logic       w_functValid;
    logic [2:0] w_functAlu;

    logic       w_iorD;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic       w_branch;
    logic [1:0] w_pcSrc;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic       w_regDst;
    logic       w_memtoReg;
    logic       w_regWrite;
    logic [2:0] w_aluControl;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_functValid = 1'b1;
        w_functAlu   = ALU_ADD;
        case (Funct)
            6'b100000: w_functAlu = ALU_ADD;
            6'b100010: w_functAlu = ALU_SUB;
            6'b100100: w_functAlu = ALU_AND;
            6'b100101: w_functAlu = ALU_OR;
            6'b101010: w_functAlu = ALU_SLT;
            default:   w_functValid = 1'b0;
        endcase
    end

    // While reset is held the outputs present the FETCH step, so the datapath sees a
    // clean fetch setup; the write enables are masked separately below.
    assign w_evalState = reset ? S_FETCH : r_state;

    always_comb begin
        w_nextState  = S_FETCH;
        w_iorD       = 1'b0;
        w_memWrite   = 1'b0;
        w_irWrite    = 1'b0;
        w_pcWrite    = 1'b0;
        w_branch     = 1'b0;
        w_pcSrc      = 2'b00;
        w_aluSrcA    = 1'b0;
        w_aluSrcB    = 2'b00;
        w_regDst     = 1'b0;
        w_memtoReg   = 1'b0;
        w_regWrite   = 1'b0;
        w_aluControl = ALU_ADD;
        w_illegal    = 1'b0;
        case (w_evalState)
            S_FETCH: begin
                w_irWrite   = 1'b1;
                w_pcWrite   = 1'b1;
                w_aluSrcB   = 2'b01;
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                w_aluSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: w_nextState = S_MEMADR;
                    OP_RTYPE:     w_nextState = S_RTYPEEX;
                    OP_BEQ:       w_nextState = S_BEQEX;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) w_nextState = S_ADDIEX;
                        else             w_illegal   = 1'b1;
                    end
                    OP_J: begin
                        if (ENABLE_J) w_nextState = S_JEX;
                        else          w_illegal   = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_nextState = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iorD      = 1'b1;
                w_nextState = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoReg = 1'b1;
                w_regWrite = 1'b1;
            end
            S_MEMWR: begin
                w_iorD     = 1'b1;
                w_memWrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_aluSrcA    = 1'b1;
                w_aluControl = w_functAlu;
                if (w_functValid) w_nextState = S_RTYPEWB;
                else              w_illegal   = 1'b1;
            end
            S_RTYPEWB: begin
                w_regDst   = 1'b1;
                w_regWrite = 1'b1;
            end
            S_BEQEX: begin
                w_aluSrcA    = 1'b1;
                w_aluControl = ALU_SUB;
                w_pcSrc      = 2'b01;
                w_branch     = 1'b1;
            end
            S_ADDIEX: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_nextState = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regWrite = 1'b1;
            end
            S_JEX: begin
                w_pcSrc   = 2'b10;
                w_pcWrite = 1'b1;
            end
            default: begin
                w_aluControl = 3'b000;
            end
        endcase
    end

    assign IorD       = w_iorD;
    assign PCSrc      = w_pcSrc;
    assign ALUSrcA    = w_aluSrcA;
    assign ALUSrcB    = w_aluSrcB;
    assign RegDst     = w_regDst;
    assign MemtoReg   = w_memtoReg;
    assign ALUcontrol = w_aluControl;
    assign state      = r_state;

    // Anything that changes architectural state stays quiet in the reset cycle.
    assign MemWrite = w_memWrite & ~reset;
    assign IRWrite  = w_irWrite  & ~reset;
    assign PCWrite  = w_pcWrite  & ~reset;
    assign Branch   = w_branch   & ~reset;
    assign RegWrite = w_regWrite & ~reset;
    assign illegal  = w_illegal  & ~reset;
    assign PCEn     = (w_pcWrite | (w_branch & Zero)) & ~reset;

endmodule
